// File: rtl/readout_sequencer.sv
// Run-level sequencer for the readout chain: arms an N-shot run, times start_collect, tracks each shot to iq_valid.
// Latency: start_collect lands delay+1 cycles after the accepted trigger; run_done/iq_timeout/aborted/config_load fire in the deciding cycle.
// Backpressure: none; triggers arriving while a shot is in flight are rejected and counted, config reloads are deferred to IDLE.
module readout_sequencer #(
    parameter int IQ_TIMEOUT = 256,
    parameter int MISS_W     = 8
) (
    input  logic              clk100,
    input  logic              reset,
    input  logic              arm,
    input  logic              abort,
    input  logic              trigger,
    input  logic              config_req,
    input  logic [13:0]       delay,
    input  logic [10:0]       sample_length,
    input  logic [15:0]       num_shots,
    input  logic              iq_valid,
    output logic              start_collect,
    output logic              config_load,
    output logic              busy,
    output logic              run_done,
    output logic              aborted,
    output logic              iq_timeout,
    output logic [15:0]       shot_cnt,
    output logic [MISS_W-1:0] missed_cnt,
    output logic              err_sticky
);

    localparam int TO_W  = $clog2(IQ_TIMEOUT + 1);
    localparam int CNT_W = (TO_W > 14) ? TO_W : 14;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(IQ_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_TRIG,
        DELAY,
        COLLECT,
        WAIT_IQ
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [13:0]       delay_q;
    logic [10:0]       len_q;
    logic [15:0]       shots_q;
    logic              cfg_pending, cfg_pending_nxt;
    logic              arm_pending, arm_pending_nxt;
    logic [15:0]       shot_cnt_nxt;
    logic [MISS_W-1:0] missed_cnt_nxt;
    logic              err_nxt;
    logic              latch_en;
    logic              load_fire;
    logic [10:0]       len_last;
    logic [15:0]       shot_inc;

    // Zero-length windows and zero-shot runs are folded to 1 when latched.
    assign len_last = len_q - 11'd1;
    assign shot_inc = shot_cnt + 16'd1;
    assign busy     = (state != IDLE);

    // config_req is not a clocked input, so keep its pulse quiet while reset is held.
    assign config_load = load_fire & reset;

    always_ff @(posedge clk100 or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            delay_q     <= '0;
            len_q       <= 11'd1;
            shots_q     <= 16'd1;
            cfg_pending <= 1'b0;
            arm_pending <= 1'b0;
            shot_cnt    <= '0;
            missed_cnt  <= '0;
            err_sticky  <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            cfg_pending <= cfg_pending_nxt;
            arm_pending <= arm_pending_nxt;
            shot_cnt    <= shot_cnt_nxt;
            missed_cnt  <= missed_cnt_nxt;
            err_sticky  <= err_nxt;
            if (latch_en) begin
                delay_q <= delay;
                len_q   <= (sample_length == 11'd0) ? 11'd1 : sample_length;
                shots_q <= (num_shots == 16'd0) ? 16'd1 : num_shots;
            end
        end
    end

    always_comb begin
        state_nxt       = state;
        cnt_nxt         = cnt;
        cfg_pending_nxt = cfg_pending;
        arm_pending_nxt = arm_pending;
        shot_cnt_nxt    = shot_cnt;
        missed_cnt_nxt  = missed_cnt;
        err_nxt         = err_sticky;
        latch_en        = 1'b0;
        load_fire       = 1'b0;
        start_collect   = 1'b0;
        run_done        = 1'b0;
        aborted         = 1'b0;
        iq_timeout      = 1'b0;

        if (state == IDLE) begin
            cnt_nxt  = '0;
            latch_en = arm;
            // A reload takes the IDLE cycle; an arm seen alongside it starts the run one cycle later.
            if (cfg_pending || config_req) begin
                load_fire       = 1'b1;
                cfg_pending_nxt = 1'b0;
                if (arm) begin
                    arm_pending_nxt = 1'b1;
                end
            end else if (arm || arm_pending) begin
                arm_pending_nxt = 1'b0;
                shot_cnt_nxt    = '0;
                missed_cnt_nxt  = '0;
                err_nxt         = 1'b0;
                state_nxt       = WAIT_TRIG;
            end
        end else begin
            if (config_req) begin
                cfg_pending_nxt = 1'b1;
            end
            if (abort) begin
                aborted   = 1'b1;
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end else begin
                if (trigger && (state != WAIT_TRIG)) begin
                    err_nxt = 1'b1;
                    if (missed_cnt != {MISS_W{1'b1}}) begin
                        missed_cnt_nxt = missed_cnt + MISS_W'(1);
                    end
                end
                case (state)
                    WAIT_TRIG: begin
                        if (trigger) begin
                            state_nxt = DELAY;
                            cnt_nxt   = '0;
                        end
                    end
                    DELAY: begin
                        if (cnt == CNT_W'(delay_q)) begin
                            start_collect = 1'b1;
                            state_nxt     = COLLECT;
                            cnt_nxt       = '0;
                        end else begin
                            cnt_nxt = cnt + CNT_W'(1);
                        end
                    end
                    COLLECT: begin
                        if (cnt == CNT_W'(len_last)) begin
                            state_nxt = WAIT_IQ;
                            cnt_nxt   = '0;
                        end else begin
                            cnt_nxt = cnt + CNT_W'(1);
                        end
                    end
                    WAIT_IQ: begin
                        if (iq_valid) begin
                            shot_cnt_nxt = shot_inc;
                            cnt_nxt      = '0;
                            if (shot_inc >= shots_q) begin
                                run_done  = 1'b1;
                                state_nxt = IDLE;
                            end else begin
                                state_nxt = WAIT_TRIG;
                            end
                        end else if (cnt == TO_LAST) begin
                            // Lost shot: shot_cnt is untouched so the same shot is retried.
                            iq_timeout = 1'b1;
                            err_nxt    = 1'b1;
                            state_nxt  = WAIT_TRIG;
                            cnt_nxt    = '0;
                        end else begin
                            cnt_nxt = cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_readout_sequencer.sv
// Bench for readout_sequencer: timestamp-based run model checked every cycle, plus directed literal checks.
module tb_readout_sequencer;

    localparam int TO       = 256;
    localparam int MW       = 8;
    localparam int MISS_MAX = 255;

    logic        clk100 = 1'b0;
    logic        reset = 1'b0;
    logic        arm = 1'b0;
    logic        abort = 1'b0;
    logic        trigger = 1'b0;
    logic        config_req = 1'b0;
    logic [13:0] delay = '0;
    logic [10:0] sample_length = '0;
    logic [15:0] num_shots = '0;
    logic        iq_valid = 1'b0;
    logic        start_collect, config_load, busy, run_done, aborted, iq_timeout, err_sticky;
    logic [15:0] shot_cnt;
    logic [MW-1:0] missed_cnt;

    readout_sequencer #(.IQ_TIMEOUT(TO), .MISS_W(MW)) dut (
        .clk100(clk100), .reset(reset), .arm(arm), .abort(abort), .trigger(trigger),
        .config_req(config_req), .delay(delay), .sample_length(sample_length),
        .num_shots(num_shots), .iq_valid(iq_valid), .start_collect(start_collect),
        .config_load(config_load), .busy(busy), .run_done(run_done), .aborted(aborted),
        .iq_timeout(iq_timeout), .shot_cnt(shot_cnt), .missed_cnt(missed_cnt),
        .err_sticky(err_sticky)
    );

    always #5 clk100 = ~clk100;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    // Model: a run is either waiting for a trigger or has a shot scheduled by absolute cycle numbers.
    bit m_run, m_wt, m_cfgp, m_armp, m_err;
    int m_delay, m_len, m_shots, m_shot, m_miss, t_start, t_iq0;
    bit n_run, n_wt, n_cfgp, n_armp, n_err;
    int n_delay, n_len, n_shots, n_shot, n_miss, n_tstart, n_tiq0;
    bit e_start, e_load, e_done, e_abort, e_to, e_busy;

    int ev_start = 0, ev_load = 0, ev_done = 0, ev_abort = 0, ev_to = 0;
    int last_start = -1, last_load = -1, last_done = -1, last_abort = -1, last_to = -1;

    task automatic model_reset();
        m_run = 0; m_wt = 0; m_cfgp = 0; m_armp = 0; m_err = 0;
        m_delay = 0; m_len = 1; m_shots = 1; m_shot = 0; m_miss = 0;
        t_start = 0; t_iq0 = 0;
    endtask

    task automatic model_eval();
        n_run = m_run; n_wt = m_wt; n_cfgp = m_cfgp; n_armp = m_armp; n_err = m_err;
        n_delay = m_delay; n_len = m_len; n_shots = m_shots; n_shot = m_shot; n_miss = m_miss;
        n_tstart = t_start; n_tiq0 = t_iq0;
        e_start = 0; e_load = 0; e_done = 0; e_abort = 0; e_to = 0;
        e_busy = m_run && reset;
        if (!reset) return;
        if (!m_run) begin
            if (arm) begin
                n_delay = int'(delay);
                n_len   = (sample_length == 0) ? 1 : int'(sample_length);
                n_shots = (num_shots == 0) ? 1 : int'(num_shots);
            end
            if (m_cfgp || config_req) begin
                e_load = 1; n_cfgp = 0;
                if (arm) n_armp = 1;
            end else if (arm || m_armp) begin
                n_armp = 0; n_run = 1; n_wt = 1; n_shot = 0; n_miss = 0; n_err = 0;
            end
        end else begin
            if (config_req) n_cfgp = 1;
            if (abort) begin
                e_abort = 1; n_run = 0;
            end else if (m_wt) begin
                if (trigger) begin
                    n_wt = 0;
                    n_tstart = cyc + m_delay + 1;
                    n_tiq0 = n_tstart + m_len + 1;
                end
            end else begin
                if (trigger) begin
                    n_err = 1;
                    if (m_miss < MISS_MAX) n_miss = m_miss + 1;
                end
                if (cyc == t_start) begin
                    e_start = 1;
                end else if (cyc >= t_iq0) begin
                    if (iq_valid) begin
                        n_shot = m_shot + 1;
                        if (n_shot >= m_shots) begin
                            e_done = 1; n_run = 0;
                        end else begin
                            n_wt = 1;
                        end
                    end else if (cyc == t_iq0 + TO - 1) begin
                        e_to = 1; n_err = 1; n_wt = 1;
                    end
                end
            end
        end
    endtask

    task automatic model_commit();
        m_run = n_run; m_wt = n_wt; m_cfgp = n_cfgp; m_armp = n_armp; m_err = n_err;
        m_delay = n_delay; m_len = n_len; m_shots = n_shots; m_shot = n_shot; m_miss = n_miss;
        t_start = n_tstart; t_iq0 = n_tiq0;
        if (!reset) model_reset();
    endtask

    task automatic compare();
        bit bad;
        n_cmp++;
        bad = (busy !== e_busy) || (start_collect !== e_start) || (config_load !== e_load) ||
              (run_done !== e_done) || (aborted !== e_abort) || (iq_timeout !== e_to) ||
              (shot_cnt !== 16'(m_shot)) || (missed_cnt !== MW'(m_miss)) || (err_sticky !== m_err);
        if (bad) begin
            n_bad++;
            if (n_bad < 30)
                $display("FAIL cycle_check cyc=%0d got busy=%0b sc=%0b cl=%0b rd=%0b ab=%0b to=%0b shot=%0d miss=%0d err=%0b expected busy=%0b sc=%0b cl=%0b rd=%0b ab=%0b to=%0b shot=%0d miss=%0d err=%0b",
                         cyc, busy, start_collect, config_load, run_done, aborted, iq_timeout,
                         shot_cnt, missed_cnt, err_sticky, e_busy, e_start, e_load, e_done,
                         e_abort, e_to, m_shot, m_miss, m_err);
        end
        if (start_collect === 1'b1) begin ev_start++; last_start = cyc; end
        if (config_load === 1'b1)   begin ev_load++;  last_load  = cyc; end
        if (run_done === 1'b1)      begin ev_done++;  last_done  = cyc; end
        if (aborted === 1'b1)       begin ev_abort++; last_abort = cyc; end
        if (iq_timeout === 1'b1)    begin ev_to++;    last_to    = cyc; end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock cycle: inputs already applied, check at negedge, advance model at posedge.
    task automatic step();
        model_eval();
        @(negedge clk100);
        compare();
        @(posedge clk100);
        model_commit();
        cyc++;
        #1;
        arm = 0; abort = 0; trigger = 0; config_req = 0; iq_valid = 0;
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    int t0, s0, d0, l0, a0, o0;

    initial begin
        model_reset();
        @(posedge clk100);
        #1;
        run_cycles(2);
        chk("reset_busy", int'(busy), 0);
        chk("reset_shot", int'(shot_cnt), 0);
        reset = 1;
        run_cycles(2);

        // Single shot, delay 10, window 20.
        delay = 10; sample_length = 20; num_shots = 1;
        s0 = ev_start; d0 = ev_done;
        arm = 1; step();
        chk("busy_after_arm", int'(busy), 1);
        t0 = cyc; trigger = 1; step();
        run_cycles(35);
        iq_valid = 1; step();
        chk("t1_start_offset", last_start - t0, 11);
        chk("t1_start_count", ev_start - s0, 1);
        chk("t1_done_offset", last_done - t0, 36);
        chk("t1_shot", int'(shot_cnt), 1);
        chk("t1_busy_after", int'(busy), 0);

        // Three shots.
        delay = 0; sample_length = 1; num_shots = 3; d0 = ev_done;
        arm = 1; step();
        for (int i = 0; i < 3; i++) begin
            trigger = 1; step();
            run_cycles(2);
            iq_valid = 1; step();
            chk("t2_shot_step", int'(shot_cnt), i + 1);
        end
        chk("t2_done_count", ev_done - d0, 1);
        chk("t2_missed", int'(missed_cnt), 0);

        // Rejected triggers during DELAY and WAIT_IQ.
        delay = 6; sample_length = 2; num_shots = 1; d0 = ev_done;
        arm = 1; step();
        trigger = 1; step();
        for (int k = 1; k <= 13; k++) begin
            if (k == 2 || k == 4 || k == 11) trigger = 1;
            if (k == 13) iq_valid = 1;
            step();
        end
        chk("t3_missed", int'(missed_cnt), 3);
        chk("t3_err", int'(err_sticky), 1);
        chk("t3_shot", int'(shot_cnt), 1);
        chk("t3_done", ev_done - d0, 1);

        // Deferred config reload.
        delay = 1; sample_length = 4; num_shots = 1; l0 = ev_load;
        arm = 1; step();
        t0 = cyc; trigger = 1; step();
        for (int k = 1; k <= 8; k++) begin
            if (k == 4) config_req = 1;
            if (k == 8) iq_valid = 1;
            step();
        end
        chk("t4_no_load_midrun", ev_load - l0, 0);
        step();
        chk("t4_load_once", ev_load - l0, 1);
        chk("t4_load_cycle", last_load - t0, 9);
        run_cycles(3);
        chk("t4_load_still_once", ev_load - l0, 1);

        // arm together with config_req.
        delay = 3; sample_length = 2; num_shots = 1;
        t0 = cyc; arm = 1; config_req = 1; step();
        chk("t4b_load_cycle", last_load - t0, 0);
        chk("t4b_busy_c1", int'(busy), 0);
        step();
        chk("t4b_busy_c2", int'(busy), 1);
        trigger = 1; step();
        for (int k = 1; k <= 7; k++) begin
            if (k == 7) iq_valid = 1;
            step();
        end
        chk("t4b_start_cycle", last_start - t0, 6);
        chk("t4b_done_cycle", last_done - t0, 9);

        // Timeout with trigger held through WAIT_IQ (saturates missed_cnt), then retry.
        delay = 2; sample_length = 3; num_shots = 1; o0 = ev_to;
        arm = 1; step();
        t0 = cyc; trigger = 1; step();
        for (int k = 1; k <= 262; k++) begin
            if (k >= 7) trigger = 1;
            step();
        end
        chk("t5_timeout_cycle", last_to - t0, 262);
        chk("t5_timeout_count", ev_to - o0, 1);
        chk("t5_shot_unchanged", int'(shot_cnt), 0);
        chk("t5_err", int'(err_sticky), 1);
        chk("t5_missed_sat", int'(missed_cnt), 255);
        chk("t5_busy", int'(busy), 1);
        trigger = 1; step();
        for (int k = 1; k <= 7; k++) begin
            if (k == 7) iq_valid = 1;
            step();
        end
        chk("t5_retry_shot", int'(shot_cnt), 1);
        chk("t5_retry_idle", int'(busy), 0);

        // Abort one cycle before start_collect.
        delay = 5; sample_length = 3; num_shots = 2; s0 = ev_start; a0 = ev_abort;
        arm = 1; step();
        t0 = cyc; trigger = 1; step();
        run_cycles(4);
        abort = 1; step();
        chk("t6_abort_cycle", last_abort - t0, 5);
        chk("t6_abort_count", ev_abort - a0, 1);
        chk("t6_busy", int'(busy), 0);
        run_cycles(3);
        chk("t6_no_start", ev_start - s0, 0);

        // Asynchronous reset mid-COLLECT.
        delay = 2; sample_length = 10; num_shots = 1;
        arm = 1; step();
        trigger = 1; step();
        trigger = 1; step();
        run_cycles(4);
        chk("t7_missed_before", int'(missed_cnt), 1);
        #2;
        reset = 0;
        model_reset();
        #1;
        chk("t7_busy_async", int'(busy), 0);
        chk("t7_missed_async", int'(missed_cnt), 0);
        chk("t7_err_async", int'(err_sticky), 0);
        chk("t7_pulses_async", int'({start_collect, config_load, run_done, aborted, iq_timeout}), 0);
        step();
        reset = 1;
        run_cycles(2);

        // Randomized traffic checked cycle by cycle against the model.
        for (int blk = 0; blk < 40; blk++) begin
            int iq_div;
            iq_div = ($urandom_range(0, 1) == 0) ? 8 : 400;
            for (int c = 0; c < 500; c++) begin
                if ($urandom_range(0, 24) == 0) begin
                    delay = 14'($urandom_range(0, 6));
                    sample_length = 11'($urandom_range(0, 5));
                    num_shots = 16'($urandom_range(0, 3));
                end
                arm        = ($urandom_range(0, 19) == 0);
                abort      = ($urandom_range(0, 299) == 0);
                trigger    = ($urandom_range(0, 14) == 0);
                config_req = ($urandom_range(0, 39) == 0);
                iq_valid   = ($urandom_range(0, iq_div - 1) == 0);
                step();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
